// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN array controllers: state encoding and
// default geometry of the systolic array.
package cnn_ctrl_pkg;

    localparam int ARRAY_SIZE_DEF = 9;
    localparam int DIM_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 14;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ARM     = 3'd2,
        ST_FILL    = 3'd3,
        ST_LAUNCH  = 3'd4,
        ST_COMPUTE = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

endpackage

// File: rtl/conv_fill_scheduler_if.sv
// Handshake and configuration bundle between the layer controller, the
// fill scheduler, input_data_rom and the systolic array.
interface conv_fill_scheduler_if #(
    parameter int DIM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int ARRAY_SIZE = 9
);
    // layer controller side
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_address;
    logic [DIM_WIDTH-1:0]  image_height;
    logic [DIM_WIDTH-1:0]  image_width;
    logic [DIM_WIDTH-1:0]  weight_size;
    logic                  busy;
    logic                  done;
    logic                  cfg_error;
    // ROM side
    logic [ADDR_WIDTH-1:0] rom_initial_address;
    logic [DIM_WIDTH-1:0]  rom_offset;
    logic [DIM_WIDTH-1:0]  rom_weight_size;
    logic [DIM_WIDTH-1:0]  rom_image_height;
    logic [DIM_WIDTH-1:0]  rom_image_width;
    logic [ARRAY_SIZE-1:0] rom_write_enable_in;
    logic                  rom_enable;
    logic                  rom_reset;
    logic                  rom_completed;
    // array side
    logic                  array_start;
    logic [ARRAY_SIZE-1:0] active_lanes;
    logic                  array_done;

    modport master (
        input  start, base_address, image_height, image_width, weight_size,
               rom_completed, array_done,
        output busy, done, cfg_error, rom_initial_address, rom_offset,
               rom_weight_size, rom_image_height, rom_image_width,
               rom_write_enable_in, rom_enable, rom_reset, array_start,
               active_lanes
    );

    modport slave (
        output start, base_address, image_height, image_width, weight_size,
               rom_completed, array_done,
        input  busy, done, cfg_error, rom_initial_address, rom_offset,
               rom_weight_size, rom_image_height, rom_image_width,
               rom_write_enable_in, rom_enable, rom_reset, array_start,
               active_lanes
    );

endinterface

// File: rtl/raster_addr_gen.sv
// Raster walker over the output pixels: tracks row/col and the ROM address
// of the top-left input pixel of the current K x K window.
module raster_addr_gen #(
    parameter int DIM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  ksize,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d, oh_q, oh_d, ow_q, ow_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign addr = addr_q;
    assign last = (row_q == oh_q - DIM_WIDTH'(1)) && (col_q == ow_q - DIM_WIDTH'(1));

    // Load on init, otherwise step one output pixel; the row wrap skips the
    // K-1 input columns that no window starts in. Address adds wrap.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        oh_d   = oh_q;
        ow_d   = ow_q;
        addr_d = addr_q;
        if (init) begin
            oh_d   = height - ksize + DIM_WIDTH'(1);
            ow_d   = width - ksize + DIM_WIDTH'(1);
            row_d  = '0;
            col_d  = '0;
            addr_d = base;
        end else if (adv) begin
            if (col_q == ow_q - DIM_WIDTH'(1)) begin
                col_d  = '0;
                row_d  = row_q + DIM_WIDTH'(1);
                addr_d = addr_q + ADDR_WIDTH'(ksize);
            end else begin
                col_d  = col_q + DIM_WIDTH'(1);
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q  <= '0;
            col_q  <= '0;
            oh_q   <= '0;
            ow_q   <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            oh_q   <= oh_d;
            ow_q   <= ow_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/conv_fill_scheduler.sv
// Convolution input-path sequencer: fills one ROM lane per output pixel and
// launches the systolic array on each group of up to ARRAY_SIZE lanes.
module conv_fill_scheduler
    import cnn_ctrl_pkg::*;
#(
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_fill_scheduler_if.master bus
);
    localparam int LANE_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    state_e                state_q, state_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DIM_WIDTH-1:0]  k_q, k_d, h_q, h_d, w_q, w_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ARRAY_SIZE-1:0] active_q, active_d, we_q, we_d;
    logic                  filled_q, filled_d;   // final output pixel already filled
    logic                  rom_en_q, rom_en_d, rom_rst_q, rom_rst_d;
    logic                  arr_start_q, arr_start_d, busy_q, busy_d;
    logic                  done_q, done_d, cfg_err_q, cfg_err_d;
    logic                  ag_init, ag_adv, ag_last, cfg_bad;
    logic [ADDR_WIDTH-1:0] ag_addr;

    assign cfg_bad = (k_q == '0) || (k_q > h_q) || (k_q > w_q);

    raster_addr_gen #(
        .DIM_WIDTH (DIM_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .init  (ag_init),
        .adv   (ag_adv),
        .base  (base_q),
        .height(h_q),
        .width (w_q),
        .ksize (k_q),
        .addr  (ag_addr),
        .last  (ag_last)
    );

    assign bus.rom_initial_address = ag_addr;
    assign bus.rom_offset          = w_q;
    assign bus.rom_weight_size     = k_q;
    assign bus.rom_image_height    = h_q;
    assign bus.rom_image_width     = w_q;
    assign bus.rom_write_enable_in = we_q;
    assign bus.rom_enable          = rom_en_q;
    assign bus.rom_reset           = rom_rst_q;
    assign bus.array_start         = arr_start_q;
    assign bus.active_lanes        = active_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.cfg_error           = cfg_err_q;

    // Next-state logic; outputs are decoded from the next state so they
    // leave the flops aligned with the state they belong to.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        k_d      = k_q;
        h_d      = h_q;
        w_d      = w_q;
        base_d   = base_q;
        active_d = active_q;
        filled_d = filled_q;
        cfg_err_d = cfg_err_q;
        ag_init  = 1'b0;
        ag_adv   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                k_d       = bus.weight_size;
                h_d       = bus.image_height;
                w_d       = bus.image_width;
                base_d    = bus.base_address;
                cfg_err_d = 1'b0;
                state_d   = ST_CHECK;
            end
            ST_CHECK: if (cfg_bad) begin
                cfg_err_d = 1'b1;
                state_d   = ST_FINISH;
            end else begin
                ag_init  = 1'b1;
                lane_d   = '0;
                active_d = '0;
                filled_d = 1'b0;
                state_d  = ST_ARM;
            end
            ST_ARM: state_d = ST_FILL;
            ST_FILL: if (bus.rom_completed) begin
                active_d[lane_q] = 1'b1;
                ag_adv           = 1'b1;
                if (ag_last) filled_d = 1'b1;
                if (ag_last || lane_q == LANE_W'(ARRAY_SIZE - 1)) begin
                    state_d = ST_LAUNCH;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = ST_ARM;
                end
            end
            ST_LAUNCH: state_d = ST_COMPUTE;
            ST_COMPUTE: if (bus.array_done) begin
                if (filled_q) begin
                    state_d = ST_FINISH;
                end else begin
                    lane_d   = '0;
                    active_d = '0;
                    state_d  = ST_ARM;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        we_d        = (state_d == ST_ARM || state_d == ST_FILL) ?
                      (ARRAY_SIZE'(1) << lane_d) : '0;
        rom_en_d    = (state_d == ST_FILL);
        rom_rst_d   = (state_d == ST_FILL);
        arr_start_d = (state_d == ST_LAUNCH);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    // FSM state, latched configuration and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            k_q         <= '0;
            h_q         <= '0;
            w_q         <= '0;
            base_q      <= '0;
            active_q    <= '0;
            we_q        <= '0;
            filled_q    <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_rst_q   <= 1'b0;
            arr_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            k_q         <= k_d;
            h_q         <= h_d;
            w_q         <= w_d;
            base_q      <= base_d;
            active_q    <= active_d;
            we_q        <= we_d;
            filled_q    <= filled_d;
            rom_en_q    <= rom_en_d;
            rom_rst_q   <= rom_rst_d;
            arr_start_q <= arr_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_conv_fill_scheduler.sv
// Bench for conv_fill_scheduler: ROM and array responders with random
// latencies, a raster-order address model, and one negedge compare process.
module tb_conv_fill_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_fill_scheduler_if #(.DIM_WIDTH(16), .ADDR_WIDTH(14), .ARRAY_SIZE(9)) bus ();

    conv_fill_scheduler #(.DIM_WIDTH(16), .ADDR_WIDTH(14), .ARRAY_SIZE(9)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus state
    logic        start_main, start_noise, rc, ad;
    logic [15:0] cfg_h, cfg_w, cfg_k;
    logic [13:0] cfg_base;
    logic [31:0] rnd_cfg;
    bit          noise = 0;
    int          rom_fix = 0, rom_max = 3;
    int          fill_cnt, fill_tgt, arr_phase, arr_wait, arr_tgt;

    assign bus.start         = start_main | start_noise;
    assign bus.base_address  = start_noise ? rnd_cfg[13:0] : cfg_base;
    assign bus.image_width   = start_noise ? rnd_cfg[29:14] : cfg_w;
    assign bus.image_height  = cfg_h;
    assign bus.weight_size   = cfg_k;
    assign bus.rom_completed = rc;
    assign bus.array_done    = ad;

    // model state
    int exp_q[$];
    bit exp_err;
    int exp_grps;
    int lane_idx, grp_idx, done_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ROM responder: completes each fill after a random number of FILL cycles
    initial begin
        rc = 0; start_noise = 0; fill_cnt = 0; fill_tgt = 1; rnd_cfg = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rc = 0; fill_cnt = 0; start_noise = 0;
            end else if (bus.rom_enable) begin
                if (fill_cnt == 0)
                    fill_tgt = (rom_fix != 0) ? rom_fix : int'($urandom_range(rom_max, 1));
                fill_cnt++;
                rc = (fill_cnt >= fill_tgt);
                if (rc) fill_cnt = 0;
                start_noise = noise && ($urandom % 2 == 1);
                rnd_cfg = $urandom;
            end else begin
                start_noise = 0;
                rc = noise && (arr_phase == 1 || $urandom % 2 == 1);
            end
        end
    end

    // Array responder: raises array_done a random number of cycles after launch
    initial begin
        ad = 0; arr_phase = 0; arr_wait = 0; arr_tgt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ad = 0; arr_phase = 0;
            end else if (arr_phase == 0) begin
                ad = noise && ($urandom % 2 == 1);
                if (bus.array_start) begin
                    ad = 0; arr_phase = 1;
                    arr_wait = int'($urandom_range(6, 1));
                    arr_tgt = arr_wait;
                end
            end else if (arr_phase == 1) begin
                arr_wait--;
                ad = (arr_wait == 0);
                if (ad) arr_phase = 2;
            end else begin
                ad = 0; arr_phase = 0;
            end
        end
    end

    // Compare process: DUT outputs against the raster model every cycle
    initial begin
        logic prev_en;
        int   en_len, cmp_cnt, cur_mask, n, end_idx;
        bit   cmp_arm;
        prev_en = 0; en_len = 0; cmp_cnt = 0; cur_mask = 0; cmp_arm = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_en = 0; cmp_arm = 0;
            end else begin
                chk("rst_vs_en", 32'(bus.rom_reset), 32'(bus.rom_enable));
                if (bus.rom_enable && !prev_en) begin
                    en_len = 0;
                    if (lane_idx < exp_q.size()) begin
                        chk("lane_addr", 32'(bus.rom_initial_address), 32'(exp_q[lane_idx]));
                        chk("lane_we", 32'(bus.rom_write_enable_in), 32'(1) << (lane_idx % 9));
                        chk("rom_offset", 32'(bus.rom_offset), 32'(cfg_w));
                        chk("rom_k", 32'(bus.rom_weight_size), 32'(cfg_k));
                        chk("rom_h", 32'(bus.rom_image_height), 32'(cfg_h));
                    end else begin
                        chk("extra_lane", 32'(lane_idx), 32'(exp_q.size()));
                    end
                    lane_idx++;
                end
                if (bus.rom_enable) en_len++;
                if (prev_en && !bus.rom_enable) begin
                    chk("fill_len", 32'(en_len), 32'(fill_tgt));
                    if (lane_idx == exp_q.size() || lane_idx % 9 == 0)
                        chk("fill_to_launch", 32'(bus.array_start), 32'(1));
                    else
                        chk("fill_to_arm", 32'(bus.rom_write_enable_in), 32'(1) << (lane_idx % 9));
                end
                if (cmp_arm) begin
                    cmp_cnt++;
                    if (bus.rom_write_enable_in != 0 || bus.done) begin
                        chk("compute_len", 32'(cmp_cnt), 32'(arr_tgt + 1));
                        cmp_arm = 0;
                    end
                end
                if (bus.array_start) begin
                    end_idx = (exp_q.size() < (grp_idx + 1) * 9) ? exp_q.size() : (grp_idx + 1) * 9;
                    n = end_idx - grp_idx * 9;
                    cur_mask = (1 << n) - 1;
                    chk("act_lanes", 32'(bus.active_lanes), 32'(cur_mask));
                    chk("grp_lanes", 32'(lane_idx), 32'(end_idx));
                    chk("we_off", 32'(bus.rom_write_enable_in), 32'(0));
                    grp_idx++;
                    cmp_arm = 1; cmp_cnt = 0;
                end
                if (arr_phase == 1)
                    chk("act_stable", 32'(bus.active_lanes), 32'(cur_mask));
                if (bus.done) begin
                    chk("done_lanes", 32'(lane_idx), 32'(exp_q.size()));
                    chk("done_grps", 32'(grp_idx), 32'(exp_grps));
                    chk("done_err", 32'(bus.cfg_error), 32'(exp_err));
                    done_cnt++;
                end
                prev_en = bus.rom_enable;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rv_addr", 32'(bus.rom_initial_address), 0);
        chk("rv_offset", 32'(bus.rom_offset), 0);
        chk("rv_dims", 32'({bus.rom_weight_size, bus.rom_image_height}), 0);
        chk("rv_we", 32'(bus.rom_write_enable_in), 0);
        chk("rv_en_start", 32'({bus.rom_enable, bus.array_start}), 0);
        chk("rv_rom_reset", 32'(bus.rom_reset), 0);
        chk("rv_active", 32'(bus.active_lanes), 0);
        chk("rv_busy_done_err", 32'({bus.busy, bus.done, bus.cfg_error}), 0);
    endtask

    // Build the expected lane address list and pulse start
    task automatic launch(input int h, input int w, input int k, input int b);
        exp_q.delete();
        exp_err = (k == 0) || (k > h) || (k > w);
        if (!exp_err)
            for (int r = 0; r < h - k + 1; r++)
                for (int c = 0; c < w - k + 1; c++)
                    exp_q.push_back((b + r * w + c) % 16384);
        exp_grps = (exp_q.size() + 8) / 9;
        lane_idx = 0; grp_idx = 0; done_cnt = 0;
        cfg_h = 16'(h); cfg_w = 16'(w); cfg_k = 16'(k); cfg_base = 14'(b);
        @(negedge clk); start_main = 1;
        @(negedge clk); start_main = 0;
        chk("check_busy", 32'(bus.busy), 1);
        chk("err_clr", 32'(bus.cfg_error), 0);
        @(negedge clk);
        if (exp_err) begin
            chk("err_done_lat", 32'(bus.done), 1);
        end else begin
            chk("first_we", 32'(bus.rom_write_enable_in), 1);
            chk("first_addr", 32'(bus.rom_initial_address), 32'(b % 16384));
        end
    endtask

    task automatic finish_wait();
        int cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        chk("done_seen", 32'(done_cnt), 1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 0; start_main = 0;
        cfg_h = 0; cfg_w = 0; cfg_k = 0; cfg_base = 0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1;

        // 5x5, K=2: 16 lanes in groups of 9 and 7
        launch(5, 5, 2, 0);
        chk("pin_n", 32'(exp_q.size()), 16);
        chk("pin_a4", 32'(exp_q[4]), 5);
        chk("pin_a8", 32'(exp_q[8]), 10);
        chk("pin_a15", 32'(exp_q[15]), 18);
        finish_wait();
        chk("t1_grps", 32'(grp_idx), 2);

        // 3x3, K=3: single lane
        launch(3, 3, 3, 100);
        finish_wait();
        chk("t2_grps", 32'(grp_idx), 1);

        // K larger than the image
        launch(5, 5, 6, 0);
        finish_wait();
        chk("err_sticky", 32'(bus.cfg_error), 1);
        chk("err_no_lanes", 32'(lane_idx), 0);

        // reset during FILL of lane 4, then replay
        rom_fix = 8;
        launch(5, 5, 2, 0);
        cyc = 0;
        while (!(lane_idx == 5 && bus.rom_enable) && cyc < 2000) begin
            @(negedge clk); cyc++;
        end
        chk("reached_lane4", 32'(lane_idx), 5);
        #1 reset = 0;
        #1 check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        reset = 1;
        rom_fix = 0;
        launch(5, 5, 2, 0);
        finish_wait();

        // ignored inputs: start during FILL, rom_completed during COMPUTE, stray array_done
        noise = 1; rom_max = 20;
        launch(5, 5, 2, 0);
        finish_wait();
        noise = 0; rom_max = 3;

        // address wrap
        launch(5, 5, 2, 16380);
        chk("pin_wrap", 32'(exp_q[4]), 1);
        finish_wait();

        // random configurations
        for (int i = 0; i < 8; i++) begin
            launch(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)),
                   int'($urandom_range(5, 0)), int'($urandom % 16384));
            finish_wait();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_fill_scheduler.md
# conv_fill_scheduler

Sequencing controller for the convolution input path. Walks every output pixel of a K×K convolution over an H×W image in raster order, programs `input_data_rom` once per systolic-array lane (start address plus one-hot lane write-enable), waits for each fill to complete, then launches the array on a group of up to ARRAY_SIZE filled lanes. It sits between the layer-level controller (start/done) and the `input_data_rom` / systolic array pair.

## Interface
- `DIM_WIDTH`, 16: width of all dimension inputs and counters.
- `ADDR_WIDTH`, 14: ROM address width.
- `ARRAY_SIZE`, 9: lanes (FIFOs) in the systolic array.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled in IDLE only; latches the configuration.
- `base_address`  in  ADDR_WIDTH  ROM address of image pixel (0,0).
- `image_height`, `image_width`, `weight_size`  in  DIM_WIDTH  H, W, K.
- `rom_initial_address`  out  ADDR_WIDTH  first pixel of the current lane's window.
- `rom_offset`  out  DIM_WIDTH  row stride, equal to latched W.
- `rom_weight_size`, `rom_image_height`, `rom_image_width`  out  DIM_WIDTH  latched K, H, W.
- `rom_write_enable_in`  out  ARRAY_SIZE  one-hot current lane; 0 outside ARM/FILL.
- `rom_enable`  out  1  high in FILL.
- `rom_reset`  out  1  active-low ROM reset; low in every state except FILL.
- `rom_completed`  in  1  ROM fill finished.
- `array_start`  out  1  one-cycle pulse launching compute.
- `active_lanes`  out  ARRAY_SIZE  lanes valid for the current group, stable from `array_start` until `array_done`.
- `array_done`  in  1  array finished the group.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion, including after a config error.
- `cfg_error`  out  1  sticky until next accepted `start`.

## Operation
- States: IDLE, CHECK, ARM, FILL, LAUNCH, COMPUTE, FINISH.
- IDLE: `start`=1 latches config, clears `cfg_error`, and moves to CHECK.
- CHECK: K=0, K>H or K>W -> set `cfg_error` and go to FINISH. Otherwise compute OH=H−K+1 and OW=W−K+1, set row=col=lane=0, set address=`base_address`, clear `active_lanes`, and go to ARM.
- ARM (1 cycle): drive the address and the one-hot lane; `rom_reset` low re-arms the ROM. Next state is FILL.
- FILL: `rom_reset`=1 and `rom_enable`=1 until `rom_completed` is sampled high. On that edge:
  - set `active_lanes[lane]`;
  - advance the position: col+1 and address+1; at col=OW−1, col=0, row+1, address+K.
- After a FILL completes: if lane=ARRAY_SIZE−1 or the last output pixel was filled, go to LAUNCH. Otherwise lane+1 and go to ARM.
- LAUNCH (1 cycle): `array_start`=1, then COMPUTE.
- COMPUTE: wait for `array_done`. If outputs remain, clear lane and `active_lanes` and go to ARM; otherwise go to FINISH.
- FINISH (1 cycle): `done`=1, then IDLE.
- Arithmetic:
  - address adds wrap modulo 2^ADDR_WIDTH;
  - OH/OW are DIM_WIDTH unsigned;
  - the comparison happens before subtraction, so no underflow.
- `rom_completed` outside FILL and `array_done` outside COMPUTE are ignored.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `rom_reset`=0;
  - `rom_enable`, `array_start`, `done`, `busy`, `cfg_error` all 0;
  - all vectors, addresses and latched dimensions 0.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously, with outputs at their reset values.
- Start latency: `start` edge -> CHECK -> first ARM, so `rom_write_enable_in` is valid 2 cycles after `start`.
- Per lane: 1 ARM cycle plus N FILL cycles, where N counts up to and including the cycle `rom_completed` is sampled.
- `rom_completed` -> next ARM, or LAUNCH, on the following cycle.
- `array_done` -> ARM of the next group, or FINISH, 1 cycle later.
- Config error: `start` -> CHECK -> FINISH, so `done` pulses 2 cycles after `start`.

## Structure
- Shared package `cnn_ctrl_pkg`: state encoding constants and the ARRAY_SIZE default, reused by the other array controllers.
- Sub-module `raster_addr_gen` holds row/col/address, the advance rule and the last-pixel flag. The FSM lives in the top module.

## Test plan
- H=W=5, K=2, base=0:
  - group 1 lane addresses 0,1,2,3,5,6,7,8,10 with `active_lanes`=9'h1FF;
  - group 2 lane addresses 11,12,13,15,16,17,18 with `active_lanes`=9'h07F;
  - exactly 2 `array_start` pulses, then 1 `done` pulse.
- H=W=3, K=3, base=100: one lane at address 100 with `active_lanes`=9'h001, one `array_start`, then `done`.
- K=6 with H=W=5: `cfg_error`=1, `done` pulses 2 cycles after `start`, and the ROM and array are never touched.
- Reset dropped during FILL of lane 4:
  - all outputs return to reset values within the same cycle and the FSM goes to IDLE;
  - a new `start` replays from address `base_address`.
- Stimulus, with `rom_completed` delayed by a random 1–20 cycles:
  - hold `rom_completed` high during COMPUTE;
  - pulse `start` during FILL;
  - expected: no state change from either input, and the address sequence matches the first scenario.
- base=16380, W=5, K=2: address wraps modulo 16384, so lane 4 address = 1.
